// File: rtl/block_requester.sv
// -----------------------------------------------------------------------------
// block_requester
//
// Initiator side of the cache-block handshake. Accepts one read or write
// command at a time from the cache controller, drives the storage block's
// enable/write/data_in pins, waits for the block's ack and returns a
// one-cycle response upstream. If the block never acks, the transaction is
// aborted after TIMEOUT wait cycles and reported with resp_error.
//
// The block numbers its word bits 0..WIDTH-1 MSB-first. Here the vectors are
// declared [WIDTH-1:0], so block bit 0 is our bit WIDTH-1. Only whole words
// are passed through, so the two numberings never need translating.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous, active-low reset
//   req_valid    upstream command valid
//   req_ready    command can be accepted (high only in IDLE)
//   req_write    1 = write, 0 = read; sampled with req_valid & req_ready
//   req_data     write data, sampled with the command
//   resp_valid   one-cycle pulse: transaction finished
//   resp_error   qualifies resp_valid; 1 = block never acked
//   resp_data    read data; updated only by a successful read
//   blk_enable   block enable
//   blk_write    block write strobe (single-cycle pulse)
//   blk_data_in  block data_in; holds the last command's data
//   blk_data_out block data_out
//   blk_ack      block ack, a level synchronous to clk
//
// Latency with an immediate ack (cycle 0 = accepting cycle):
//   cycle 1 ISSUE (write pulse), cycle 2 WAIT_ACK (ack sampled),
//   cycle 3 RELEASE, cycle 4 RESP (resp_valid). Five cycles per command.
// -----------------------------------------------------------------------------
module block_requester #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 15   // legal range 1..255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_data,
   output logic             resp_valid,
   output logic             resp_error,
   output logic [WIDTH-1:0] resp_data,
   output logic             blk_enable,
   output logic             blk_write,
   output logic [WIDTH-1:0] blk_data_in,
   input  logic [WIDTH-1:0] blk_data_out,
   input  logic             blk_ack
);

   // Wide enough to hold TIMEOUT itself, so the post-increment on the final
   // wait cycle cannot wrap back to a value that matches CNT_LAST again.
   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      RELEASE,
      RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             write_q;   // direction of the command in flight
   logic             err_q;     // in-flight command timed out

   assign req_ready = (state == IDLE);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: state_nxt gets a default before the case, so no path through this
   // block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (req_valid)                       state_nxt = ISSUE;
         ISSUE:                                         state_nxt = WAIT_ACK;
         // Ack is tested first, so an ack on the last allowed cycle wins.
         WAIT_ACK: if (blk_ack || wait_cnt == CNT_LAST) state_nxt = RELEASE;
         // After a timeout the ack level is irrelevant; otherwise wait for
         // the block to return to idle. A stuck ack stalls here by design.
         RELEASE:  if (err_q || !blk_ack)               state_nxt = RESP;
         RESP:                                          state_nxt = IDLE;
         default:                                       state_nxt = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath and registered outputs
   // --------------------------------------------------------------------------
   // NOTE: every register here is reset, including the data words, because
   // the block and the controller both see them straight after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt    <= '0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         resp_valid  <= 1'b0;
         resp_error  <= 1'b0;
         resp_data   <= '0;
         blk_enable  <= 1'b0;
         blk_write   <= 1'b0;
         blk_data_in <= '0;
      end else begin
         // Pulsed outputs fall back to zero unless set below.
         blk_write  <= 1'b0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;

         case (state)
            IDLE: begin
               if (req_valid) begin
                  write_q     <= req_write;
                  blk_data_in <= req_data;
                  blk_enable  <= 1'b1;
                  // Registered here so the strobe is high for exactly the
                  // ISSUE cycle.
                  blk_write   <= req_write;
               end
            end

            ISSUE: begin
               wait_cnt <= '0;
            end

            WAIT_ACK: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (blk_ack) begin
                  blk_enable <= 1'b0;
                  if (!write_q) begin
                     resp_data <= blk_data_out;
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  blk_enable <= 1'b0;
                  err_q      <= 1'b1;
               end
            end

            RELEASE: begin
               if (err_q || !blk_ack) begin
                  resp_valid <= 1'b1;
                  resp_error <= err_q;
               end
            end

            RESP: begin
               err_q <= 1'b0;
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_block_requester.sv
// -----------------------------------------------------------------------------
// tb_block_requester
//
// Self-checking bench for block_requester (WIDTH = 16, TIMEOUT = 15).
// A table of command records is driven cycle by cycle while the bench plays
// the storage block. Expected responses are queued when a command is
// accepted and compared when resp_valid pulses. Hand-written sequences
// cover back-to-back commands and a reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_block_requester;

   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 15;

   logic             clk;
   logic             reset_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [WIDTH-1:0] req_data;
   logic             resp_valid;
   logic             resp_error;
   logic [WIDTH-1:0] resp_data;
   logic             blk_enable;
   logic             blk_write;
   logic [WIDTH-1:0] blk_data_in;
   logic [WIDTH-1:0] blk_data_out;
   logic             blk_ack;

   block_requester #(
      .WIDTH  (WIDTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_data    (req_data),
      .resp_valid  (resp_valid),
      .resp_error  (resp_error),
      .resp_data   (resp_data),
      .blk_enable  (blk_enable),
      .blk_write   (blk_write),
      .blk_data_in (blk_data_in),
      .blk_data_out(blk_data_out),
      .blk_ack     (blk_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One command record: stimulus plus the response it must produce.
   // ack_wait:     wait cycles before ack rises (0 = first WAIT_ACK cycle),
   //               negative = block never acks.
   // release_hold: extra cycles ack stays high after the ack cycle.
   typedef struct {
      logic             write;
      logic [WIDTH-1:0] data;
      int               ack_wait;
      logic [WIDTH-1:0] rdata;
      int               release_hold;
      logic             exp_err;
      logic [WIDTH-1:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic             err;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[8];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && resp_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: resp_valid=1 with no command pending at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_error", resp_error, e.err);
            check("resp_data", resp_data, e.data);
         end
      end
   end

   // Drives one command and plays the block. Entered just after a rising
   // edge with the DUT in IDLE; leaves the same way.
   // Control word compared each cycle: {blk_enable, blk_write, resp_valid, req_ready}.
   task automatic drive_txn(input vec_t v);
      bit timed_out;
      int n_wait;
      timed_out = (v.ack_wait < 0);
      n_wait    = timed_out ? TIMEOUT : v.ack_wait + 1;

      // Cycle 0: IDLE, command presented and accepted at the next edge.
      req_valid = 1'b1;
      req_write = v.write;
      req_data  = v.data;
      blk_ack   = 1'b0;
      @(negedge clk);
      check("idle_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0001);
      sb_q.push_back('{err: v.exp_err, data: v.exp_rdata});

      // Cycle 1: ISSUE.
      tick();
      req_valid = 1'b0;
      req_data  = ~v.data;
      @(negedge clk);
      check("issue_ctl", {blk_enable, blk_write, resp_valid, req_ready},
            {1'b1, v.write, 2'b00});
      check("issue_data_in", blk_data_in, v.data);

      // WAIT_ACK cycles.
      for (int k = 0; k < n_wait; k++) begin
         tick();
         if (!timed_out && k == v.ack_wait) begin
            blk_ack      = 1'b1;
            blk_data_out = v.rdata;
         end else begin
            blk_ack      = 1'b0;
            blk_data_out = WIDTH'($urandom);
         end
         @(negedge clk);
         check("wait_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b1000);
      end

      // RELEASE.
      if (timed_out) begin
         tick();
         blk_ack = (v.release_hold > 0);
         @(negedge clk);
         check("release_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0000);
      end else begin
         for (int h = 0; h < v.release_hold; h++) begin
            tick();
            blk_ack      = 1'b1;
            blk_data_out = WIDTH'($urandom);
            @(negedge clk);
            check("stall_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0000);
         end
         tick();
         blk_ack = 1'b0;
         @(negedge clk);
         check("release_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0000);
      end

      // RESP: content is compared by the scoreboard.
      tick();
      blk_ack = 1'b0;
      @(negedge clk);
      check("resp_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0010);
      check("data_in_hold", blk_data_in, v.data);

      // Back in IDLE.
      tick();
      @(negedge clk);
      check("done_ctl", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0001);
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] model_rdata;
      int               accepts;
      int               w_first;
      int               w_second;
      int               stall_cycles;
      logic [WIDTH-1:0] data_second;

      vecs[0] = '{write: 1'b1, data: 16'b0000_1111_0000_1111, ack_wait: 0,  rdata: 16'hDEAD,
                  release_hold: 0, exp_err: 1'b0, exp_rdata: 16'h0000};
      vecs[1] = '{write: 1'b0, data: 16'h0000, ack_wait: 3,  rdata: 16'hA5C3,
                  release_hold: 0, exp_err: 1'b0, exp_rdata: 16'hA5C3};
      vecs[2] = '{write: 1'b0, data: 16'h1357, ack_wait: -1, rdata: 16'h1234,
                  release_hold: 0, exp_err: 1'b1, exp_rdata: 16'hA5C3};
      vecs[3] = '{write: 1'b0, data: 16'h2468, ack_wait: 14, rdata: 16'h5A3C,
                  release_hold: 0, exp_err: 1'b0, exp_rdata: 16'h5A3C};
      vecs[4] = '{write: 1'b1, data: 16'hFFFF, ack_wait: 14, rdata: 16'hBEEF,
                  release_hold: 0, exp_err: 1'b0, exp_rdata: 16'h5A3C};
      vecs[5] = '{write: 1'b1, data: 16'h8001, ack_wait: -1, rdata: 16'hCAFE,
                  release_hold: 1, exp_err: 1'b1, exp_rdata: 16'h5A3C};
      vecs[6] = '{write: 1'b0, data: 16'h0F0F, ack_wait: 1,  rdata: 16'h0001,
                  release_hold: 4, exp_err: 1'b0, exp_rdata: 16'h0001};
      vecs[7] = '{write: 1'b0, data: 16'h7E7E, ack_wait: 0,  rdata: 16'hFFFF,
                  release_hold: 0, exp_err: 1'b0, exp_rdata: 16'hFFFF};

      // Reset state.
      reset_n      = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_data     = '0;
      blk_ack      = 1'b0;
      blk_data_out = '0;
      #1 reset_n = 1'b0;
      #1;
      check("reset_ctl", {blk_enable, blk_write, resp_valid, resp_error, req_ready}, 5'b00001);
      check("reset_resp_data", resp_data, 16'h0000);
      check("reset_data_in", blk_data_in, 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // Table-driven commands.
      for (int i = 0; i < 8; i++) begin
         drive_txn(vecs[i]);
      end
      model_rdata = vecs[7].exp_rdata;

      // Back-to-back writes with req_valid held high; the block acks in the
      // cycle after the write pulse.
      req_valid    = 1'b1;
      req_write    = 1'b1;
      req_data     = 16'h1111;
      blk_ack      = 1'b0;
      accepts      = 0;
      w_first      = -1;
      w_second     = -1;
      stall_cycles = 0;
      data_second  = '0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (blk_write) begin
            if (w_first < 0) begin
               w_first = c;
            end else if (w_second < 0) begin
               w_second    = c;
               data_second = blk_data_in;
            end
         end
         if (req_valid && req_ready) begin
            accepts++;
            sb_q.push_back('{err: 1'b0, data: model_rdata});
         end else if (req_valid) begin
            stall_cycles++;
         end
         tick();
         blk_ack = blk_enable && !blk_write;
         if (accepts == 1) req_data  = 16'h2222;
         if (accepts == 2) req_valid = 1'b0;
      end
      blk_ack = 1'b0;
      check("b2b_accepts", accepts, 2);
      check("b2b_pulse_gap", w_second - w_first, 5);
      check("b2b_ready_low", stall_cycles, 4);
      check("b2b_second_data", data_second, 16'h2222);

      // Reset pulsed during WAIT_ACK of a read that is never acked.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_data  = 16'h7777;
      tick();                 // ISSUE
      req_valid = 1'b0;
      tick();                 // WAIT_ACK
      tick();
      tick();
      #3 reset_n = 1'b0;
      #1;
      check("midrst_ctl", {blk_enable, blk_write, resp_valid, resp_error, req_ready}, 5'b00001);
      check("midrst_resp_data", resp_data, 16'h0000);
      check("midrst_data_in", blk_data_in, 16'h0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) tick();     // any stray response is caught by the scoreboard
      @(negedge clk);
      check("post_rst_idle", {blk_enable, blk_write, resp_valid, req_ready}, 4'b0001);
      tick();

      // The next command after reset proceeds normally.
      drive_txn('{write: 1'b0, data: 16'h4242, ack_wait: 2, rdata: 16'h3C3C,
                  release_hold: 0, exp_err: 1'b0, exp_rdata: 16'h3C3C});

      check("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
